// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// The add-3 threshold lives here so the digit adjuster and any future users agree on it.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] ADJ3_THRESHOLD = 4'd5;

  // A digit at or above 5 would reach 10+ after doubling, so it is corrected first.
  function automatic logic needs_adj3(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit >= ADJ3_THRESHOLD);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Valid digits are 0..9, so the result is at most 12 and never carries out of 4 bits.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = needs_adj3(digit_i) ? (digit_i + BCD_DIGIT_W'(3)) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Outputs are registered and only change together with the done pulse.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   shift_q,   shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               sticky_q,  sticky_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic               ovf_q,     ovf_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;

  logic [BCD_W-1:0]   adjusted;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_adj3 u_adj3 (
        .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (adjusted[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_LOAD;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // The top adjusted bit is shifted out of the scratch register; remember it.
        {scratch_d, shift_d} = {adjusted[BCD_W-2:0], shift_q, 1'b0};
        sticky_d             = sticky_q | adjusted[BCD_W-1];
        cnt_d                = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_d   = scratch_d;
          ovf_d   = sticky_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bcd      = bcd_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed handshake cases plus random values,
// checked against an arithmetic decimal-digit model (8-bit and 10-bit instances).
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy, done, ovf;

  logic        start10;
  logic [9:0]  bin10;
  logic [11:0] bcd10;
  logic        busy10, done10, ovf10;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] held_bcd;
  logic        held_ovf;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (ovf)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut10 (
    .clk      (clk),
    .rst      (rst),
    .start    (start10),
    .bin      (bin10),
    .bcd      (bcd10),
    .busy     (busy10),
    .done     (done10),
    .overflow (ovf10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: low three decimal digits of v, overflow when v needs a fourth digit.
  function automatic logic [11:0] ref_bcd(input int unsigned v);
    logic [11:0]  r;
    int unsigned  m;
    m = v % 1000;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return (v > 999);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point with the converter idle; returns just after the accepting edge.
  task automatic launch8(input logic [7:0] v);
    bin   = v;
    start = 1'b1;
    step();
    start = 1'b0;
    bin   = 8'($urandom);
    check("busy_after_accept", busy, 1);
  endtask

  // Runs the remaining WIDTH edges; optionally re-pulses start before edge inject_cycle.
  task automatic finish8(input logic [7:0] v, input int inject_cycle, input logic [7:0] inject_val);
    for (int i = 1; i <= 8; i++) begin
      if (i == inject_cycle) begin
        start = 1'b1;
        bin   = inject_val;
      end
      step();
      if (i == inject_cycle) start = 1'b0;
      if (i < 8) begin
        check("busy_during", busy, 1);
        check("done_early", done, 0);
        check("bcd_held", bcd, held_bcd);
        check("ovf_held", ovf, held_ovf);
      end
    end
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("bcd_result", bcd, ref_bcd(v));
    check("ovf_result", ovf, ref_ovf(v));
    held_bcd = ref_bcd(v);
    held_ovf = ref_ovf(v);
    $display("conv8  bin=%0d bcd=%03h ovf=%0b", v, bcd, ovf);
  endtask

  task automatic conv10(input logic [9:0] v);
    int cycles;
    bin10   = v;
    start10 = 1'b1;
    step();
    start10 = 1'b0;
    bin10   = 10'($urandom);
    cycles  = 0;
    while (!done10 && cycles < 20) begin
      step();
      cycles++;
    end
    check("lat10", cycles, 10);
    check("bcd10", bcd10, ref_bcd(v));
    check("ovf10", ovf10, ref_ovf(v));
    $display("conv10 bin=%0d bcd=%03h ovf=%0b cycles=%0d", v, bcd10, ovf10, cycles);
    step();
    check("done10_low", done10, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bin      = '0;
    start10  = 1'b0;
    bin10    = '0;
    held_bcd = '0;
    held_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", bcd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    step();

    launch8(8'd0);
    finish8(8'd0, 0, 8'd0);
    step();
    check("done_one_cycle", done, 0);

    launch8(8'd255);
    finish8(8'd255, 0, 8'd0);
    step();
    check("done_one_cycle", done, 0);

    // Back-to-back: second start issued in the done cycle.
    launch8(8'd99);
    finish8(8'd99, 0, 8'd0);
    launch8(8'd100);
    check("done_drop_b2b", done, 0);
    finish8(8'd100, 0, 8'd0);
    step();

    // Start re-pulsed while busy must be ignored.
    launch8(8'd42);
    finish8(8'd42, 3, 8'd7);
    for (int i = 0; i < 10; i++) begin
      step();
      check("no_extra_done", done, 0);
      check("no_extra_busy", busy, 0);
    end

    // Asynchronous reset mid-conversion.
    launch8(8'd200);
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_bcd", bcd, 0);
    check("arst_done", done, 0);
    check("arst_ovf", ovf, 0);
    held_bcd = '0;
    held_ovf = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    launch8(8'd137);
    finish8(8'd137, 0, 8'd0);
    step();

    for (int t = 0; t < 20; t++) begin
      logic [7:0] v;
      v = 8'($urandom);
      launch8(v);
      finish8(v, 0, 8'd0);
      if ($urandom_range(1) == 0) step();
    end
    step();

    conv10(10'd1023);
    conv10(10'd999);
    conv10(10'd1000);
    for (int t = 0; t < 10; t++) conv10(10'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
